// File: rtl/jtframe_spi_dlrx.sv
// SPI download receiver: decodes the MiST data_io ROM stream on SS2
// (0x53 flag, 0x54 data, 0x55 index) into a byte-wide ioctl write port.
`timescale 1ns/1ps

module jtframe_spi_dlrx #(
    parameter int              AW         = 22,
    parameter logic [AW-1:0]   ADDR_START = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_DI,
    input  logic          SPI_SS2,
    output logic          ioctl_downloading,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_data,
    output logic          ioctl_wr,
    output logic          ioctl_done,
    output logic          ioctl_ovf
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FLAG,
        ST_INDEX,
        ST_DATA,
        ST_SKIP
    } state_t;

    state_t     state, state_next;
    logic [2:0] sck_sr;
    logic [1:0] di_sr;
    logic [1:0] ss_sr;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       sck_rise;
    logic       ss_high;
    logic       byte_done;
    logic [7:0] rx_byte;

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update from pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sr <= 3'b000;
            di_sr  <= 2'b00;
            ss_sr  <= 2'b11;
        end else begin
            sck_sr <= {sck_sr[1:0], SPI_SCK};
            di_sr  <= {di_sr[0], SPI_DI};
            ss_sr  <= {ss_sr[0], SPI_SS2};
        end
    end

    assign sck_rise  = sck_sr[1] & ~sck_sr[2];
    assign ss_high   = ss_sr[1];
    // A byte finishing while SS2 is already seen high is dropped.
    assign byte_done = sck_rise & ~ss_high & (bit_cnt == 3'd7);
    assign rx_byte   = {shift[6:0], di_sr[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
        end else if (ss_high) begin
            bit_cnt <= 3'd0;
        end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!ss_high) state_next = ST_CMD;
            ST_CMD: begin
                if (byte_done) begin
                    case (rx_byte)
                        8'h53:   state_next = ST_FLAG;
                        8'h54:   state_next = ST_DATA;
                        8'h55:   state_next = ST_INDEX;
                        default: state_next = ST_SKIP;
                    endcase
                end
            end
            ST_FLAG, ST_INDEX: if (byte_done) state_next = ST_SKIP;
            default: ;
        endcase
        if (ss_high) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ioctl_downloading <= 1'b0;
            ioctl_index       <= 8'd0;
            ioctl_addr        <= ADDR_START;
            ioctl_data        <= 8'd0;
            ioctl_wr          <= 1'b0;
            ioctl_done        <= 1'b0;
            ioctl_ovf         <= 1'b0;
        end else begin
            ioctl_wr   <= 1'b0;
            ioctl_done <= 1'b0;
            // Address advances the cycle after the strobe so it is stable during it.
            if (ioctl_wr) begin
                ioctl_addr <= ioctl_addr + AW'(1);
                if (&ioctl_addr) ioctl_ovf <= 1'b1;
            end
            if (byte_done) begin
                case (state)
                    ST_FLAG: begin
                        ioctl_downloading <= rx_byte[0];
                        if (rx_byte[0] && !ioctl_downloading) begin
                            ioctl_addr <= ADDR_START;
                            ioctl_ovf  <= 1'b0;
                        end
                        if (!rx_byte[0] && ioctl_downloading) ioctl_done <= 1'b1;
                    end
                    ST_INDEX: ioctl_index <= rx_byte;
                    ST_DATA: begin
                        ioctl_data <= rx_byte;
                        ioctl_wr   <= ioctl_downloading;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
